// File: rtl/agc_pkg.sv
// Shared definitions for the one's complement sequential divider:
// default word width and the controller state encoding.
package agc_pkg;

  localparam int NUM_BIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ones_comp_abs.sv
// One's complement magnitude extractor: the sign bit selects whether the
// remaining bits are passed through or inverted, so +0 and -0 both map to 0.
module ones_comp_abs #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH-2:0] mag
);

  assign sign = value[WIDTH-1];
  assign mag  = sign ? ~value[WIDTH-2:0] : value[WIDTH-2:0];

endmodule

// File: rtl/ones_comp_seq_div.sv
// Sequential restoring divider for one's complement operands.
// A 2*NUM_BIT dividend is divided by a NUM_BIT divisor, one quotient bit per
// CALC cycle. Divide-by-zero and quotient overflow are detected up front and
// reported one cycle after acceptance.
//
// state | meaning
// IDLE  | ready=1, waiting for start; operands latched on accept
// CALC  | one restoring step per cycle, NUM_BIT-1 cycles
// DONE  | done=1 for one cycle, results valid
module ones_comp_seq_div
  import agc_pkg::*;
#(
  parameter int NUM_BIT = agc_pkg::NUM_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*NUM_BIT-1:0] numer,
  input  logic [NUM_BIT-1:0]   denom,
  output logic                 ready,
  output logic                 done,
  output logic [NUM_BIT-1:0]   quot,
  output logic [NUM_BIT-1:0]   remain,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int NW    = 2 * NUM_BIT;
  localparam int CNT_W = $clog2(NUM_BIT);

  logic                 n_sign;
  logic                 d_sign;
  logic [NW-2:0]        nmag;
  logic [NUM_BIT-2:0]   dmag;

  state_t               state;
  state_t               state_nxt;

  logic [NUM_BIT-2:0]   dmag_q;
  logic [NUM_BIT-2:0]   rem_q;
  // Holds the not-yet-consumed dividend bits; quotient bits shift in at the
  // bottom as dividend bits shift out at the top.
  logic [NUM_BIT-2:0]   qbits_q;
  logic                 sq_q;
  logic                 sr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 err_dbz;
  logic                 err_ovf;
  logic [NUM_BIT-1:0]   r_shift;
  logic [NUM_BIT-1:0]   d_ext;
  logic                 ge;
  logic [NUM_BIT-2:0]   rem_step;
  logic [NUM_BIT-2:0]   q_step;
  logic                 last_step;

  ones_comp_abs #(.WIDTH(NW)) u_abs_numer (
    .value (numer),
    .sign  (n_sign),
    .mag   (nmag)
  );

  ones_comp_abs #(.WIDTH(NUM_BIT)) u_abs_denom (
    .value (denom),
    .sign  (d_sign),
    .mag   (dmag)
  );

  // The upper half of the dividend must be below the divisor, otherwise the
  // quotient cannot fit in NUM_BIT-1 magnitude bits.
  assign err_dbz = (dmag == '0);
  assign err_ovf = (nmag[NW-2:NUM_BIT-1] >= {1'b0, dmag});

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift   = {rem_q, qbits_q[NUM_BIT-2]};
    d_ext     = {1'b0, dmag_q};
    ge        = (r_shift >= d_ext);
    rem_step  = ge ? (NUM_BIT-1)'(r_shift - d_ext) : r_shift[NUM_BIT-2:0];
    q_step    = {qbits_q[NUM_BIT-3:0], ge};
    last_step = (count_q == CNT_W'(NUM_BIT - 2));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (err_dbz || err_ovf) state_nxt = DONE;
          else                    state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmag_q      <= '0;
      rem_q       <= '0;
      qbits_q     <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      count_q     <= '0;
      quot        <= '0;
      remain      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmag_q      <= dmag;
            // Top bit of the upper half is zero whenever CALC is entered.
            rem_q       <= nmag[NW-3:NUM_BIT-1];
            qbits_q     <= nmag[NUM_BIT-2:0];
            sq_q        <= n_sign ^ d_sign;
            sr_q        <= n_sign;
            count_q     <= '0;
            quot        <= '0;
            remain      <= '0;
            div_by_zero <= err_dbz;
            overflow    <= !err_dbz && err_ovf;
          end
        end
        CALC: begin
          rem_q   <= rem_step;
          qbits_q <= q_step;
          count_q <= count_q + CNT_W'(1);
          if (last_step) begin
            // Negative zero results are kept as all-ones on purpose.
            quot   <= sq_q ? ~{1'b0, q_step}   : {1'b0, q_step};
            remain <= sr_q ? ~{1'b0, rem_step} : {1'b0, rem_step};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_comp_seq_div.sv
// Scoreboard bench for ones_comp_seq_div: directed operations push their
// hand-computed results; a negedge monitor pops and compares on every done.
module tb_ones_comp_seq_div;

  localparam int N = 15;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] numer = '0;
  logic [N-1:0]   denom = '0;
  logic           ready;
  logic           done;
  logic [N-1:0]   quot;
  logic [N-1:0]   remain;
  logic           div_by_zero;
  logic           overflow;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  ones_comp_seq_div #(.NUM_BIT(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .numer       (numer),
    .denom       (denom),
    .ready       (ready),
    .done        (done),
    .quot        (quot),
    .remain      (remain),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quot",        quot,        e.q);
        chk("remain",      remain,      e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("overflow",    overflow,    e.ovf);
        chk("latency",     cyc - e.acc + 1, e.lat);
      end
      done_cnt++;
    end
  end

  // Caller is at a negedge; issues one operation, optionally pokes start
  // mid-CALC with other operands, waits for done, then checks hold.
  task automatic run_op(input logic [2*N-1:0] nu, input logic [N-1:0] de,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edbz, input logic eovf, input bit poke);
    exp_t e;
    int   w;
    int   base;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
    numer = nu;
    denom = de;
    start = 1'b1;
    base  = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.ovf = eovf;
    e.lat = (edbz || eovf) ? 1 : 15;
    e.acc = cyc;
    sb.push_back(e);
    chk("clr_quot",   quot,   '0);
    chk("clr_remain", remain, '0);
    if (poke) begin
      repeat (4) @(negedge clk);
      chk("busy_ready", ready, 1'b0);
      numer = 30'd49151;
      denom = 15'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    w = 0;
    while (done_cnt == base && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == base) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    chk("hold_quot",   quot,        eq);
    chk("hold_remain", remain,      er);
    chk("hold_dbz",    div_by_zero, edbz);
    chk("hold_ovf",    overflow,    eovf);
    chk("idle_ready",  ready,       1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done",  done,  1'b0);
    chk("rst_quot",  quot,  '0);
    @(negedge clk);
    rst_n = 1'b1;

    //      numer            denom     quot      remain    dbz  ovf  poke
    run_op(30'd100,        15'd7,    15'd14,   15'd2,    1'b0, 1'b0, 1'b0);
    run_op(30'h3FFFFF9B,   15'd7,    15'h7FF1, 15'h7FFD, 1'b0, 1'b0, 1'b0);
    run_op(30'd100,        15'h7FF8, 15'h7FF1, 15'd2,    1'b0, 1'b0, 1'b0);
    run_op(30'h3FFFFF9B,   15'h7FF8, 15'd14,   15'h7FFD, 1'b0, 1'b0, 1'b0);
    run_op(30'd100,        15'h7FFF, 15'd0,    15'd0,    1'b1, 1'b0, 1'b0);
    run_op(30'h1FFFFFFF,   15'd0,    15'd0,    15'd0,    1'b1, 1'b0, 1'b0);
    run_op(30'd49152,      15'd3,    15'd0,    15'd0,    1'b0, 1'b1, 1'b0);
    run_op(30'd49151,      15'd3,    15'd16383,15'd2,    1'b0, 1'b0, 1'b0);
    run_op(30'h3FFFFFFF,   15'd5,    15'h7FFF, 15'h7FFF, 1'b0, 1'b0, 1'b0);
    run_op(30'h0FFFFFFF,   15'h3FFF, 15'd0,    15'd0,    1'b0, 1'b1, 1'b0);
    run_op(30'h0FFFBFFF,   15'h3FFF, 15'h3FFF, 15'h3FFE, 1'b0, 1'b0, 1'b0);

    // Abort mid-CALC with reset: nothing may come out for this operation.
    numer = 30'd100;
    denom = 15'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("calc_ready", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready,       1'b1);
    chk("abort_done",  done,        1'b0);
    chk("abort_quot",  quot,        '0);
    chk("abort_rem",   remain,      '0);
    chk("abort_dbz",   div_by_zero, 1'b0);
    chk("abort_ovf",   overflow,    1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(30'd100,        15'd7,    15'd14,   15'd2,    1'b0, 1'b0, 1'b0);

    // start during CALC with different operands must be ignored.
    run_op(30'd100,        15'd7,    15'd14,   15'd2,    1'b0, 1'b0, 1'b1);

    repeat (20) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
